// File: rtl/excess3_serial_adder.sv
// Digit-serial Excess-3 decimal adder, LSD first, one digit pair per handshake, 1-cycle latency.
// Backpressure passes through the single output register; optional subtract mode via EXCESS3_SUB_EN.
module excess3_serial_adder #(
  parameter bit FLUSH_CARRY = 1'b1,
  parameter bit CHECK_CODES = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       in_last,
`ifdef EXCESS3_SUB_EN
  input  logic       in_sub,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_last,
  output logic       out_carry,
  output logic       out_err
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state_q, state_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] out_digit_q, out_digit_d;
  logic       out_last_q, out_last_d;
  logic       out_carry_q, out_carry_d;
  logic       out_err_q, out_err_d;
  logic       carry_q, carry_d;

  logic       out_free, accept, sub_eff, cin, cout, beat_err, flush_go;
  logic [3:0] b_eff, digit;
  logic [4:0] sum;

  function automatic logic bad_code(input logic [3:0] x);
    return (x < 4'd3) || (x > 4'd12);
  endfunction

`ifdef EXCESS3_SUB_EN
  // first_q marks the LSD of an operand, where the subtract flag is sampled.
  logic first_q, first_d, sub_q, sub_d;
  assign sub_eff = first_q ? in_sub : sub_q;
  assign cin     = carry_q | (first_q & sub_eff);
`else
  assign sub_eff = 1'b0;
  assign cin     = carry_q;
`endif

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == RUN) && out_free;
  assign accept   = in_valid && in_ready;

  // Nines' complement of an Excess-3 digit is its bitwise inverse.
  assign b_eff    = sub_eff ? ~in_b : in_b;
  assign sum      = {1'b0, in_a} + {1'b0, b_eff} + {4'b0000, cin};
  assign cout     = sum[4];
  assign digit    = cout ? (sum[3:0] + 4'd3) : (sum[3:0] - 4'd3);
  assign beat_err = CHECK_CODES && (bad_code(in_a) || bad_code(in_b));
  assign flush_go = FLUSH_CARRY && in_last && cout && !sub_eff;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_digit_d = out_digit_q;
    out_last_d  = out_last_q;
    out_carry_d = out_carry_q;
    out_err_d   = out_err_q;
    carry_d     = carry_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_digit_d = digit;
      out_err_d   = beat_err;
      out_last_d  = in_last && !flush_go;
      out_carry_d = in_last && !flush_go && cout;
      carry_d     = in_last ? 1'b0 : cout;
      state_d     = flush_go ? FLUSH : RUN;
    end else if (state_q == FLUSH && out_free) begin
      out_valid_d = 1'b1;
      out_digit_d = 4'b0100;
      out_err_d   = 1'b0;
      out_last_d  = 1'b1;
      out_carry_d = 1'b1;
      state_d     = RUN;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef EXCESS3_SUB_EN
  always_comb begin
    first_d = first_q;
    sub_d   = sub_q;
    if (accept) begin
      first_d = in_last;
      if (first_q) sub_d = in_sub;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      sub_q   <= 1'b0;
    end else begin
      first_q <= first_d;
      sub_q   <= sub_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      out_digit_q <= 4'd0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_err_q   <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
      out_err_q   <= out_err_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_digit = out_digit_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_excess3_serial_adder.sv
// Bench for excess3_serial_adder: directed vector table, hand sequences, and random decimal operands.
module tb_excess3_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [3:0] in_a, in_b;
  logic       out_valid, out_ready, out_last, out_carry, out_err;
  logic [3:0] out_digit;
`ifdef EXCESS3_SUB_EN
  logic       in_sub;
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  always #5 clk = ~clk;

  excess3_serial_adder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
`ifdef EXCESS3_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_last(out_last), .out_carry(out_carry), .out_err(out_err)
  );

  typedef struct packed {logic [3:0] a; logic [3:0] b; logic last; logic sub;} beat_t;
  typedef struct packed {logic [3:0] d; logic l; logic c; logic e;} obs_t;
  typedef struct packed {int nb; beat_t [2:0] bt; int ne; obs_t [3:0] ex; int rdy; bit fchk;} vec_t;

  beat_t in_q[$];
  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  vec_t  vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // out_carry only carries meaning on the final digit, so it is compared there only.
  task automatic cmp_out(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act.d !== exp.d || act.l !== exp.l || act.e !== exp.e || (exp.l && act.c !== exp.c)) begin
      errors++;
      $display("FAIL %s: got d=%b l=%b c=%b e=%b expected d=%b l=%b c=%b e=%b",
               name, act.d, act.l, act.c, act.e, exp.d, exp.l, exp.c, exp.e);
    end
  endtask

  // rdy_mode: 0 always ready, 1 stall 3 cycles at first valid, 2 random.
  task automatic run(input string name, input int rdy_mode, input bit gaps, input bit flush_chk);
    int   cyc = 0, hold = 0;
    bit   prev_stall = 0, last_fired = 0;
    obs_t prev = '0, cur;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      in_valid = (in_q.size() > 0) && (!gaps || $urandom_range(3) != 0);
      if (in_q.size() > 0) begin
        in_a = in_q[0].a; in_b = in_q[0].b; in_last = in_q[0].last;
`ifdef EXCESS3_SUB_EN
        in_sub = in_q[0].sub;
`endif
      end
      out_ready = 1'b1;
      if (rdy_mode == 1 && out_valid && hold < 3) begin out_ready = 1'b0; hold++; end
      if (rdy_mode == 2) out_ready = ($urandom_range(2) != 0);
      #1;
      cur = '{out_digit, out_last, out_carry, out_err};
      if (flush_chk && last_fired) begin
        chk({name, " flush_in_ready"}, in_ready, 0);
        last_fired = 0;
      end
      if (prev_stall) begin
        chk({name, " hold_valid"}, out_valid, 1);
        chk({name, " hold_fields"}, cur, prev);
      end
      if (out_valid && !out_ready) chk({name, " stall_in_ready"}, in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s unexpected digit: got %b expected none", name, out_digit);
        end else cmp_out(name, cur, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev = cur;
      if (in_valid && in_ready) begin
        last_fired = in_q[0].last;
        void'(in_q.pop_front());
      end
    end
    if (exp_q.size() > 0 || in_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: got %0d outputs pending expected 0", name, exp_q.size());
      exp_q.delete(); in_q.delete();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  // Decimal reference: operands as digit arrays, result from integer arithmetic.
  task automatic push_op(input int n, input int da[8], input int db[8], input bit sub);
    longint A = 0, B = 0, p = 1, R;
    bit c, fl;
    for (int i = 0; i < n; i++) begin
      A += da[i] * p; B += db[i] * p; p *= 10;
      in_q.push_back('{4'(da[i] + 3), 4'(db[i] + 3), i == n - 1, (i == 0) ? sub : 1'($urandom)});
    end
    R = sub ? (A - B + p) : (A + B);
    c = (R >= p);
    if (c) R -= p;
    fl = c && !sub;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{4'(R % 10 + 3), (i == n - 1) && !fl, (i == n - 1) && c && !fl, 1'b0});
      R /= 10;
    end
    if (fl) exp_q.push_back('{4'b0100, 1'b1, 1'b1, 1'b0});
  endtask

  initial begin
    int da[8], db[8];
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
`ifdef EXCESS3_SUB_EN
    in_sub = 1'b0;
`endif
    #12;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_digit", out_digit, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_carry", out_carry, 0);
    chk("rst out_err", out_err, 0);
    @(negedge clk) rst_n = 1'b1;

    vt[0] = '0; vt[0].nb = 2; vt[0].ne = 2;
    vt[0].bt[0] = '{4'b1010, 4'b1000, 1'b0, 1'b0}; vt[0].bt[1] = '{4'b0101, 4'b0100, 1'b1, 1'b0};
    vt[0].ex[0] = '{4'b0101, 1'b0, 1'b0, 1'b0};    vt[0].ex[1] = '{4'b0111, 1'b1, 1'b0, 1'b0};
    vt[1] = '0; vt[1].nb = 2; vt[1].ne = 3; vt[1].fchk = 1;
    vt[1].bt[0] = '{4'b1000, 4'b1010, 1'b0, 1'b0}; vt[1].bt[1] = '{4'b1100, 4'b0011, 1'b1, 1'b0};
    vt[1].ex[0] = '{4'b0101, 1'b0, 1'b0, 1'b0};    vt[1].ex[1] = '{4'b0011, 1'b0, 1'b0, 1'b0};
    vt[1].ex[2] = '{4'b0100, 1'b1, 1'b1, 1'b0};
    vt[2] = vt[0]; vt[2].rdy = 1;
    vt[3] = '0; vt[3].nb = 1; vt[3].ne = 2; vt[3].fchk = 1;
    vt[3].bt[0] = '{4'b1111, 4'b0011, 1'b1, 1'b0};
    vt[3].ex[0] = '{4'b0101, 1'b0, 1'b0, 1'b1};    vt[3].ex[1] = '{4'b0100, 1'b1, 1'b1, 1'b0};
    vt[4] = '0; vt[4].nb = 1; vt[4].ne = 1;
    vt[4].bt[0] = '{4'b0100, 4'b0100, 1'b1, 1'b0}; vt[4].ex[0] = '{4'b0101, 1'b1, 1'b0, 1'b0};
    vt[5] = '0; vt[5].nb = 1; vt[5].ne = 1;
    vt[5].bt[0] = '{4'b0011, 4'b1100, 1'b1, 1'b0}; vt[5].ex[0] = '{4'b1100, 1'b1, 1'b0, 1'b0};
    vt[6] = '0; vt[6].nb = 1; vt[6].ne = 1;
    vt[6].bt[0] = '{4'b0010, 4'b0011, 1'b1, 1'b0}; vt[6].ex[0] = '{4'b0010, 1'b1, 1'b0, 1'b1};

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vt[v].nb; i++) in_q.push_back(vt[v].bt[i]);
      for (int i = 0; i < vt[v].ne; i++) exp_q.push_back(vt[v].ex[i]);
      run($sformatf("vec%0d", v), vt[v].rdy, 1'b0, vt[v].fchk);
    end

    // Reset while a digit is pending must clear everything, including the carry.
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'b1000; in_b = 4'b1010; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid", out_valid, 0);
    chk("mid_rst out_digit", out_digit, 0);
    chk("mid_rst fields", {out_last, out_carry, out_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    in_q.push_back('{4'b0100, 4'b0100, 1'b1, 1'b0});
    exp_q.push_back('{4'b0101, 1'b1, 1'b0, 1'b0});
    run("post_rst 01+01", 0, 1'b0, 1'b0);

`ifdef EXCESS3_SUB_EN
    in_q.push_back('{4'b0101, 4'b1000, 1'b0, 1'b1});
    in_q.push_back('{4'b0111, 4'b0100, 1'b1, 1'b0});
    exp_q.push_back('{4'b1010, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{4'b0101, 1'b1, 1'b1, 1'b0});
    run("sub 42-15", 0, 1'b0, 1'b0);
`endif

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 5; k++) begin
        int n;
        n = $urandom_range(1, 6);
        for (int i = 0; i < 8; i++) begin
          da[i] = $urandom_range(0, 9);
          db[i] = $urandom_range(0, 9);
        end
        push_op(n, da, db, HAS_SUB && ($urandom_range(1) == 1));
      end
      run($sformatf("rand%0d", r), 2, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
